// File: rtl/reg_count_ctrl_pkg.sv
// Shared encodings for the two-register accumulate sequencer.
package reg_count_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // A-input mux select
  localparam logic SEL_DIN = 1'b0;
  localparam logic SEL_SUM = 1'b1;

  // sequence mode
  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

endpackage

// File: rtl/reg_step_counter.sv
// Loadable down-counter holding the remaining accumulate steps.
// Priority is clr > load > dec, and it saturates at zero.
module reg_step_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] d,
  output logic [CNT_W-1:0] q,
  output logic             is_one
);

  // Counter register: clear, load, or decrement toward zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                q <= '0;
    else if (clr)              q <= '0;
    else if (load)             q <= d;
    else if (dec && q != '0)   q <= q - 1'b1;
  end

  assign is_one = (q == CNT_W'(1));

endmodule

// File: rtl/reg_count_ctrl.sv
// Sequencer for an external A/B register pair with adder: loads A,
// optionally loads B, then applies A <= A+B a latched number of times.
module reg_count_ctrl
  import reg_count_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [CNT_W-1:0] step_cnt,
  output logic             load_a,
  output logic             load_b,
  output logic             a_sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_left
);

  state_t           state;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rem;
  logic             rem_one;
  logic             cnt_clr, cnt_load, cnt_dec;

  // Abort wipes the remaining count; the count is loaded on the way into
  // LOAD_B so LOAD_B can already decide between RUN and DONE.
  assign cnt_clr  = abort && (state != S_IDLE);
  assign cnt_load = (state == S_LOAD_A) && (mode_q == MODE_ACC);
  assign cnt_dec  = (state == S_RUN);

  reg_step_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .load   (cnt_load),
    .dec    (cnt_dec),
    .d      (cnt_q),
    .q      (rem),
    .is_one (rem_one)
  );

  // Sequencer state and the operands latched at start acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mode_q <= MODE_LOAD;
      cnt_q  <= '0;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start && !abort) begin
          mode_q <= mode;
          cnt_q  <= step_cnt;
          state  <= S_LOAD_A;
        end
        S_LOAD_A: state <= (mode_q == MODE_ACC) ? S_LOAD_B : S_DONE;
        S_LOAD_B: state <= (rem == '0) ? S_DONE : S_RUN;
        // rem==0 in RUN cannot happen; treated as finished for safety
        S_RUN:    if (rem_one || rem == '0) state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Moore output decode from the registered state and counter.
  always_comb begin
    load_a    = (state == S_LOAD_A) || (state == S_RUN);
    load_b    = (state == S_LOAD_B);
    a_sel     = (state == S_RUN) ? SEL_SUM : SEL_DIN;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    step_left = (state == S_RUN) ? rem : '0;
  end

endmodule

// File: tb/tb_reg_count_ctrl.sv
// Bench for reg_count_ctrl: transaction-level expected-output model plus a
// small A/B/adder datapath driven by the controller.
module tb_reg_count_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [CNT_W-1:0] step_cnt = '0;
  logic             load_a, load_b, a_sel, busy, done;
  logic [CNT_W-1:0] step_left;

  reg_count_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .step_cnt(step_cnt), .load_a(load_a), .load_b(load_b), .a_sel(a_sel),
    .busy(busy), .done(done), .step_left(step_left)
  );

  always #5 clk = ~clk;

  int n_err = 0, n_chk = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d (0x%0h) exp=%0d (0x%0h)", nm, $time, act, act, exp, exp);
    end
  endtask

  // ---- bench datapath: A (din / sum mux) and B registers ----
  logic [7:0] da_v = 8'd0, db_v = 8'd0, din, ra = 8'd0, rb = 8'd0;
  assign din = load_b ? db_v : da_v;
  always @(posedge clk) begin
    if (load_a) ra <= a_sel ? (ra + rb) : din;
    if (load_b) rb <= din;
  end

  // ---- expected-output model: a sequence is a list of per-cycle outputs ----
  typedef struct packed {
    logic             la, lb, sel, busy, done;
    logic [CNT_W-1:0] sl;
  } exp_t;

  function automatic exp_t mk(input logic la, lb, sel, bz, dn, input int sl);
    exp_t e;
    e.la = la; e.lb = lb; e.sel = sel; e.busy = bz; e.done = dn;
    e.sl = CNT_W'(sl);
    return e;
  endfunction

  exp_t cur = '0;
  exp_t mq[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur = '0;
      mq.delete();
    end else if (cur.busy) begin
      if (abort) begin
        cur = '0;
        mq.delete();
      end else if (mq.size() > 0) cur = mq.pop_front();
      else cur = '0;
    end else if (start && !abort) begin
      mq.push_back(mk(1, 0, 0, 1, 0, 0));
      if (mode) begin
        mq.push_back(mk(0, 1, 0, 1, 0, 0));
        for (int k = int'(step_cnt); k >= 1; k--) mq.push_back(mk(1, 0, 1, 1, 0, k));
      end
      mq.push_back(mk(0, 0, 0, 1, 1, 0));
      cur = mq.pop_front();
    end
  end

  logic [8:0] outv;
  assign outv = {load_a, load_b, a_sel, busy, done, step_left};

  // Every cycle out of reset, the outputs must match the model.
  always @(negedge clk) if (rst_n) chk("model", int'(outv), int'(cur));

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // One directed sequence with literal latency and final-A expectations.
  task automatic run_seq(input string nm, input logic m, input int c, input int da,
                         input int db, input int exp_lat, input int exp_a);
    int n, nb, ns;
    da_v = 8'(da); db_v = 8'(db);
    mode = m; step_cnt = CNT_W'(c); start = 1'b1;
    tick();
    start = 1'b0; mode = 1'($urandom); step_cnt = CNT_W'($urandom);
    n = 0; nb = 0; ns = 0;
    do begin
      @(negedge clk);
      n++;
      if (load_b) nb++;
      if (load_a && a_sel) ns++;
    end while (!done && n < 40);
    chk({nm, "_latency"}, n, exp_lat);
    chk({nm, "_loadb_cycles"}, nb, m ? 1 : 0);
    chk({nm, "_sum_loads"}, ns, m ? c : 0);
    chk({nm, "_regA"}, int'(ra), exp_a);
    tick();
  endtask

  initial begin
    int nd, ns;
    // reset state, before any clock edge
    #1 rst_n = 1'b0;
    #2 chk("reset_outputs", int'(outv), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); chk("idle_busy", int'(busy), 0);
    tick();

    run_seq("acc3",  1'b1, 3,  5,  3, 6,  14);
    run_seq("load0", 1'b0, 7,  9,  4, 2,  9);
    run_seq("cnt0",  1'b1, 0,  11, 6, 3,  11);
    run_seq("cnt15", 1'b1, 15, 1,  2, 18, 31);

    // abort in the second RUN cycle
    da_v = 8'd4; db_v = 8'd7; mode = 1'b1; step_cnt = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    ns = 0; nd = 0;
    repeat (3) begin @(negedge clk); if (load_a && a_sel) ns++; end
    tick(); abort = 1'b1;
    @(negedge clk); if (load_a && a_sel) ns++;
    chk("abort_run2_step_left", int'(step_left), 3);
    tick(); abort = 1'b0;
    @(negedge clk); chk("abort_busy", int'(busy), 0);
    repeat (5) begin @(negedge clk); if (done) nd++; if (load_a && a_sel) ns++; end
    chk("abort_no_done", nd, 0);
    chk("abort_sum_loads", ns, 2);
    chk("abort_regA", int'(ra), 18);

    // abort beats start in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk); chk("abort_beats_start", int'(busy), 0);
    tick();

    // reset in the middle of RUN
    mode = 1'b1; step_cnt = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("pre_reset_step_left", int'(step_left), 2);
    rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'(outv), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk); chk("post_reset_busy", int'(busy), 0);
    tick();

    // start held high: back-to-back sequences, one done each
    mode = 1'b1; step_cnt = 4'd2; start = 1'b1; nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (i == 19) start = 1'b0;
    end
    chk("held_start_dones", nd, 4);
    tick();

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 400; i++) begin
      start    = ($urandom_range(0, 2) == 0);
      abort    = ($urandom_range(0, 11) == 0);
      mode     = 1'($urandom);
      step_cnt = CNT_W'($urandom_range(0, 6));
      da_v     = 8'($urandom);
      db_v     = 8'($urandom);
      tick();
    end
    start = 1'b0; abort = 1'b0;
    repeat (25) tick();
    chk("final_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
